accumulator_io_source: RTL
==========================

Name: accumulator_io_source

Overview:
- Input-port device that produces the IOIn word consumed by accumulatorFull; it is the writer side of the accumulator's IO input.
- Accepts 16-bit words from an external producer (switch bank, UART bridge or test driver) over a valid/ready handshake.
- Buffers the words in a small show-ahead FIFO.
- Presents the head word on IOIn and advances one entry each time the accumulator asserts a read strobe.

Parameters:
- WIDTH, 16, data word width; matches accumulator IOIn.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- EMPTY_VALUE, 16'h0000, value driven on IOIn while the FIFO is empty.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on the CLK rising edge).
- src_data  input  WIDTH  word offered by the producer.
- src_valid  input  1  producer has a word on src_data.
- src_ready  output  1  FIFO can accept a word this cycle.
- io_rd  input  1  accumulator consumes the current IOIn word this cycle.
- IOIn  output  WIDTH  head-of-FIFO word (show-ahead), or EMPTY_VALUE when empty.
- io_valid  output  1  IOIn holds a real buffered word.
- count  output  clog2(DEPTH)+1  number of occupied entries.
- underflow  output  1  sticky flag: io_rd was seen while empty.

Behaviour:
- Reset (reset==0 at a CLK edge):
  - rd_ptr, wr_ptr and count are cleared to 0; underflow is cleared to 0.
  - FIFO contents are not cleared.
  - After the edge: IOIn=EMPTY_VALUE, io_valid=0, src_ready=1.
  - Reset overrides any push or pop in the same cycle.
- Flag definitions:
  - src_ready = (count != DEPTH), derived from registered count only; no combinational path from io_rd.
  - io_valid = (count != 0).
  - IOIn = io_valid ? mem[rd_ptr] : EMPTY_VALUE, combinational from registers.
- Push (src_valid && src_ready at the edge):
  - mem[wr_ptr] <= src_data; wr_ptr advances by 1, modulo DEPTH.
  - Zero-latency visibility: a word pushed into an empty FIFO appears on IOIn on the cycle after the edge.
- Pop (io_rd && io_valid at the edge): rd_ptr advances by 1, modulo DEPTH. The next entry, or EMPTY_VALUE, appears on IOIn on the following cycle.
- Count update:
  - Push only: count+1.
  - Pop only: count-1.
  - Push and pop together: unchanged, both pointers advance.
- Full: src_ready=0; src_valid is ignored, no data is lost or overwritten. A pop in the same cycle frees one slot, but src_ready rises only on the next cycle.
- Empty:
  - io_rd with io_valid=0 performs no pointer change and sets underflow=1.
  - underflow stays set until reset.
  - If a push and io_rd arrive together while empty, the push is stored, the pop is discarded, and underflow is set.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. Full and empty are distinguished by count, never by pointer equality.
- Producer holding src_valid high with src_ready low must keep src_data stable; the block does not check this.
- No internal state machine beyond the pointer and count registers.
- Throughput: one push and one pop per cycle sustained.

Test Plan:
- Reset: hold reset=0 for 2 cycles with src_valid=1 and io_rd=1 -> after release, count=0, IOIn=16'h0000, io_valid=0, src_ready=1, underflow=0.
- Single word: push 16'hFF00, then idle one cycle -> IOIn=16'hFF00, io_valid=1, count=1. Pulse io_rd -> next cycle IOIn=16'h0000, io_valid=0, count=0.
- Fill and order:
  - Push 16'h0001..16'h0005 back-to-back, no reads -> after 4 pushes src_ready=0, count=4; 16'h0005 is held off until a read frees a slot.
  - Then pulse io_rd 4 times -> IOIn shows 0001, 0002, 0003, 0004 in order.
- Simultaneous push and pop at count=2, repeated 10 cycles with incrementing data -> count stays 2, IOIn sequence is contiguous across pointer wrap, no duplicate or skipped word.
- Underflow: io_rd=1 while empty -> underflow=1, pointers unchanged. A later push of 16'hABCD still reads back correctly. Reset clears underflow.
- Reset mid-operation: with count=3, drive reset=0 for one cycle -> count=0, IOIn=EMPTY_VALUE. The next push of 16'h1234 reads back as 16'h1234, with no stale entries.

Source files
------------

// File: rtl/accumulator_io_source.sv
// accumulator_io_source
//   Writer side of the accumulator's IO input. Words from an external
//   producer arrive over a valid/ready handshake, are buffered in a small
//   show-ahead FIFO, and the head word is presented on IOIn. Each io_rd
//   strobe from the accumulator retires the head entry.
//
// Ports
//   CLK        system clock, rising edge
//   reset      synchronous active-low reset
//   src_data   word offered by the producer
//   src_valid  producer has a word on src_data
//   src_ready  FIFO can take a word this cycle (registered count only)
//   io_rd      accumulator consumes the current IOIn word
//   IOIn       head word, or EMPTY_VALUE when empty
//   io_valid   IOIn holds a real buffered word
//   count      occupied entries
//   underflow  sticky: io_rd seen while empty
module accumulator_io_source #(
    parameter int              WIDTH       = 16,
    parameter int              DEPTH       = 4,
    parameter logic [WIDTH-1:0] EMPTY_VALUE = '0
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         src_data,
    input  logic                     src_valid,
    output logic                     src_ready,
    input  logic                     io_rd,
    output logic [WIDTH-1:0]         IOIn,
    output logic                     io_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          underflow_q, underflow_d;

    logic push, pop;

    // Flags come from registered state only, so there is no combinational
    // path from io_rd to src_ready.
    always_comb begin
        src_ready = (count_q != CW'(DEPTH));
        io_valid  = (count_q != '0);
        IOIn      = io_valid ? mem_q[rd_ptr_q] : EMPTY_VALUE;
        count     = count_q;
        underflow = underflow_q;
    end

    always_comb begin
        push        = src_valid && src_ready;
        pop         = io_rd && io_valid;
        // DEPTH is a power of two, so pointers wrap by plain overflow.
        rd_ptr_d    = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        count_d     = count_q;
        if (push && !pop)
            count_d = count_q + CW'(1);
        else if (pop && !push)
            count_d = count_q - CW'(1);
        // A read strobe on an empty FIFO is discarded but remembered.
        underflow_d = underflow_q | (io_rd & ~io_valid);
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is not reset; stale contents are unreachable once the
    // pointers and count are cleared. Reset still blocks the write so a
    // push during reset leaves no trace.
    always_ff @(posedge CLK) begin
        if (reset && push)
            mem_q[wr_ptr_q] <= src_data;
    end

endmodule
